// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
//   Definitions shared by both ends of the serial link: the piso_serializer
//   transmitter and the shift_reg deserializer on the receiving side.
//
//   Contents:
//     ser_state_t        transmitter FSM state (idle / shifting a word)
//     SER_DEFAULT_WIDTH  default link word size in bits
//     ser_cnt_width()    width of a bit-position counter for a given word
//                        size, never less than one bit
// ---------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    localparam int unsigned SER_DEFAULT_WIDTH = 8;

    // $clog2(1) is 0. That would give a zero-width counter, so clamp it to 1.
    function automatic int unsigned ser_cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// ---------------------------------------------------------------------------
// piso_hold_buf
//   Single-entry holding buffer for the serializer. It parks one word that
//   arrives while the shift register is busy. This lets the next word start
//   with no idle bit when the current word ends.
//
//   Ports:
//     clk         rising-edge clock
//     reset       asynchronous, active-high reset
//     wr_en       store wr_data; the entry becomes full
//     wr_data     word to store
//     pop         release the stored word; the entry becomes empty
//     hold        stored word
//     hold_full   entry holds a word that has not been sent
//     load_ready  the buffer can take a word (!hold_full)
//
//   The owner never asserts wr_en and pop in the same cycle. A write needs
//   an empty entry and a pop needs a full one. The write branch still has
//   priority, so the entry behaviour does not depend on that rule.
// ---------------------------------------------------------------------------
module piso_hold_buf
    import serial_pkg::*;
#(
    parameter int unsigned width = SER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [width-1:0] wr_data,
    input  logic             pop,
    output logic [width-1:0] hold,
    output logic             hold_full,
    output logic             load_ready
);

    // NOTE: sequential state uses non-blocking assignments (<=). Every flop
    // then samples values from before the edge, so the order of flops
    // inside the block does not matter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the data word is reset as well as the flag. It is a
            // single register, not a RAM, so the reset is cheap. It also
            // keeps hold at a known value in waveforms after reset.
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (wr_en) begin
            hold      <= wr_data;
            hold_full <= 1'b1;
        end else if (pop) begin
            hold_full <= 1'b0;
        end
    end

    // Driven only from a flop, so the handshake has no path from load_valid
    // back to load_ready.
    assign load_ready = !hold_full;

endmodule

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in, serial-out transmitter. It accepts a width-bit word over a
//   valid/ready handshake and sends it LSB-first, one bit per cycle in which
//   shift_en is high. A one-word holding buffer lets back-to-back words run
//   with no gap. Feed the same shift_en to the shift_reg receiver's enable;
//   after width enabled cycles the receiver holds the word.
//
//   Ports:
//     clk           rising-edge clock
//     reset         asynchronous, active-high reset
//     load_valid    load_data holds a word to send
//     load_data     word to serialize
//     load_ready    a word can be accepted this cycle (!hold_full)
//     shift_en      the link takes serial_out at this rising edge
//     serial_out    current bit (shreg[0]); registered, 0 when idle
//     serial_valid  serial_out carries a payload bit (state is SHIFT)
//     done          one-cycle pulse after the last bit of a word is taken
// ---------------------------------------------------------------------------
module piso_serializer
    import serial_pkg::*;
#(
    parameter int unsigned width = SER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [width-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             done
);

    localparam int unsigned      CNT_W    = ser_cnt_width(width);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(width - 1);

    ser_state_t       state;
    logic [width-1:0] shreg;
    logic [CNT_W-1:0] cnt;

    logic [width-1:0] hold;
    logic             hold_full;

    logic             accept;       // handshake completes at this edge
    logic             last_bit;     // this edge takes the final bit of a word
    logic             hold_pop;     // parked word moves into shreg
    logic             direct_load;  // incoming word goes straight into shreg
    logic             hold_wr;      // incoming word is parked in hold

    // At the last-bit edge a parked word has priority over an incoming one.
    // Sending the incoming word first would reorder the stream. An incoming
    // word is parked only when it cannot go straight into shreg.
    always_comb begin
        // NOTE: every signal gets a default before any condition. No path
        // then leaves a signal unassigned, so no latch can be inferred.
        accept      = 1'b0;
        last_bit    = 1'b0;
        hold_pop    = 1'b0;
        direct_load = 1'b0;
        hold_wr     = 1'b0;

        accept   = load_valid && load_ready;
        last_bit = (state == SER_SHIFT) && shift_en && (cnt == LAST_CNT);

        if (last_bit && hold_full) begin
            hold_pop = 1'b1;
        end
        if (last_bit && !hold_full && accept) begin
            direct_load = 1'b1;
        end
        if ((state == SER_SHIFT) && accept && !direct_load) begin
            hold_wr = 1'b1;
        end
    end

    piso_hold_buf #(
        .width (width)
    ) u_hold_buf (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (hold_wr),
        .wr_data    (load_data),
        .pop        (hold_pop),
        .hold       (hold),
        .hold_full  (hold_full),
        .load_ready (load_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SER_IDLE;
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            // done is high only in the cycle after a last-bit edge.
            done <= last_bit;

            case (state)
                SER_IDLE: begin
                    // shift_en is ignored here. shreg is already 0, so the
                    // line stays low.
                    if (accept) begin
                        shreg <= load_data;
                        cnt   <= '0;
                        state <= SER_SHIFT;
                    end
                end

                SER_SHIFT: begin
                    // Without shift_en all state holds and the bit stays on
                    // the line.
                    if (shift_en) begin
                        if (!last_bit) begin
                            shreg <= shreg >> 1;
                            cnt   <= cnt + CNT_W'(1);
                        end else if (hold_full) begin
                            shreg <= hold;
                            cnt   <= '0;
                        end else if (accept) begin
                            shreg <= load_data;
                            cnt   <= '0;
                        end else begin
                            shreg <= '0;
                            cnt   <= '0;
                            state <= SER_IDLE;
                        end
                    end
                end

                default: begin
                    state <= SER_IDLE;
                end
            endcase
        end
    end

    assign serial_out   = shreg[0];
    assign serial_valid = (state == SER_SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//   Self-checking bench for piso_serializer. It instantiates two DUTs:
//   width 8 for the main tests and width 1 for the single-bit corner case.
//   The drivers push each accepted word into a scoreboard queue. A separate
//   monitor acts as the receiver: it rebuilds words from the link,
//   compares each word against the queue and tracks the done timing.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;

    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         shift_en;
    logic         serial_out;
    logic         serial_valid;
    logic         done;

    logic         load_valid1;
    logic [0:0]   load_data1;
    logic         load_ready1;
    logic         shift_en1;
    logic         serial_out1;
    logic         serial_valid1;
    logic         done1;

    always #5 clk = ~clk;

    piso_serializer #(.width(W)) u_dut8 (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .shift_en     (shift_en),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .done         (done)
    );

    piso_serializer #(.width(1)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid1),
        .load_data    (load_data1),
        .load_ready   (load_ready1),
        .shift_en     (shift_en1),
        .serial_out   (serial_out1),
        .serial_valid (serial_valid1),
        .done         (done1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Hand-computed stimulus and expectations.
    bit a5_bits [8]  = '{1, 0, 1, 0, 0, 1, 0, 1};             // 0xA5 LSB-first
    bit gap_en  [12] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0, 1};
    bit gap_out [12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1}; // 0x81 under gap_en

    // ---------------- scoreboard / monitor (width 8) ----------------
    logic [W-1:0] exp_q [$];
    logic [W-1:0] rx;
    int           nbits     = 0;
    bit           done_due  = 1'b0;
    int           words_rx  = 0;
    int           run_len   = 0;
    int           max_run   = 0;
    bit           seen_busy = 1'b0;
    int           cyc       = 0;
    int           done_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            nbits    = 0;
            done_due = 1'b0;
            run_len  = 0;
        end else begin
            check("done_timing", done, done_due);
            done_due = 1'b0;
            if (done) done_cyc.push_back(cyc);
            if (!load_ready) seen_busy = 1'b1;
            if (!serial_valid) begin
                check("idle_line_low", serial_out, 0);
                run_len = 0;
            end else begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end
            if (serial_valid && shift_en) begin
                rx = {serial_out, rx[W-1:1]};
                nbits++;
                if (nbits == W) begin
                    nbits    = 0;
                    done_due = 1'b1;
                    words_rx++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected actual=%0h required=none", rx);
                    end else begin
                        check("rx_word", rx, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- monitor (width 1) ----------------
    bit bits1 [$];
    int done1_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (serial_valid1) bits1.push_back(serial_out1);
            if (done1) done1_cnt++;
        end
    end

    // Offer one word from posedge+1. Wait (bounded) until load_ready is seen
    // at a negedge; the word is then accepted at the next rising edge.
    task automatic send(input logic [W-1:0] w);
        int t = 0;
        load_valid = 1'b1;
        load_data  = w;
        @(negedge clk);
        while (!load_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!load_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_ready required=ready word=%0h", w);
        end else begin
            exp_q.push_back(w);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int rx0;
        reset       = 1'b1;
        load_valid  = 1'b0;
        load_data   = '0;
        shift_en    = 1'b0;
        load_valid1 = 1'b0;
        load_data1  = '0;
        shift_en1   = 1'b0;

        // ---- reset state; a load offered during reset is dropped ----
        repeat (2) @(posedge clk);
        #1;
        load_valid = 1'b1;
        load_data  = 8'h99;
        @(negedge clk);
        check("rst_serial_out", serial_out, 0);
        check("rst_serial_valid", serial_valid, 0);
        check("rst_load_ready", load_ready, 1);
        check("rst_done", done, 0);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        reset      = 1'b0;
        @(negedge clk);
        check("load_dropped_in_reset", serial_valid, 0);

        // ---- single word 0xA5 ----
        @(posedge clk);
        #1;
        shift_en = 1'b1;
        rx0      = words_rx;
        send(8'hA5);
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("a5_bit", serial_out, a5_bits[i]);
            check("a5_valid", serial_valid, 1);
        end
        @(negedge clk);
        check("a5_done", done, 1);
        check("a5_idle_valid", serial_valid, 0);
        check("a5_idle_out", serial_out, 0);
        check("a5_words", words_rx - rx0, 1);

        // ---- back-to-back 0x3C, 0xC3, 0x0F ----
        @(posedge clk);
        #1;
        max_run   = 0;
        seen_busy = 1'b0;
        done_cyc.delete();
        rx0 = words_rx;
        send(8'h3C);
        send(8'hC3);
        send(8'h0F);
        load_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("b2b_run", max_run, 24);
        check("b2b_busy_seen", seen_busy, 1);
        check("b2b_words", words_rx - rx0, 3);
        check("b2b_done_cnt", done_cyc.size(), 3);
        if (done_cyc.size() == 3) begin
            check("b2b_done_gap1", done_cyc[1] - done_cyc[0], 8);
            check("b2b_done_gap2", done_cyc[2] - done_cyc[1], 8);
        end

        // ---- gapped enable, 0x81 ----
        shift_en = 1'b0;
        rx0      = words_rx;
        send(8'h81);
        load_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            shift_en = gap_en[k];
            @(negedge clk);
            check("gap_bit", serial_out, gap_out[k]);
            check("gap_valid", serial_valid, 1);
            @(posedge clk);
            #1;
        end
        shift_en = 1'b0;
        @(negedge clk);
        check("gap_done", done, 1);
        check("gap_idle", serial_valid, 0);
        check("gap_words", words_rx - rx0, 1);

        // ---- same-cycle load at the last bit, hold empty ----
        @(posedge clk);
        #1;
        shift_en  = 1'b1;
        max_run   = 0;
        seen_busy = 1'b0;
        done_cyc.delete();
        rx0 = words_rx;
        send(8'hF0);
        load_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        send(8'h55);
        load_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("direct_run", max_run, 16);
        check("direct_hold_never_full", seen_busy, 0);
        check("direct_words", words_rx - rx0, 2);
        check("direct_done_cnt", done_cyc.size(), 2);
        if (done_cyc.size() == 2) check("direct_done_gap", done_cyc[1] - done_cyc[0], 8);

        // ---- asynchronous reset mid-word ----
        send(8'hFF);
        send(8'h77);
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_hold_full", load_ready, 0);
        check("pre_rst_valid", serial_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_out", serial_out, 0);
        check("async_rst_valid", serial_valid, 0);
        check("async_rst_done", done, 0);
        check("async_rst_ready", load_ready, 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rx0   = words_rx;
        send(8'h12);
        load_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("post_rst_words", words_rx - rx0, 1);
        check("post_rst_idle", serial_valid, 0);

        // ---- width 1: stream 1, 0, 1 ----
        shift_en1 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            load_valid1 = 1'b1;
            load_data1  = (j == 1) ? 1'b0 : 1'b1;
            @(negedge clk);
            check("w1_ready", load_ready1, 1);
            @(posedge clk);
            #1;
        end
        load_valid1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("w1_bit_cnt", bits1.size(), 3);
        if (bits1.size() == 3) begin
            check("w1_bit0", bits1[0], 1);
            check("w1_bit1", bits1[1], 0);
            check("w1_bit2", bits1[2], 1);
        end
        check("w1_done_cnt", done1_cnt, 3);
        check("w1_idle", serial_valid1, 0);

        // ---- end of run ----
        check("scoreboard_empty", exp_q.size(), 0);
        check("rx_partial_bits", nbits, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
